// File: rtl/tx_serializer.sv
// tx_serializer: single-buffered word-to-serial framer with start strobe, MSB-first data and inter-frame gap
module tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  transmit,
  output logic                  transmit_data,
  output logic                  busy,
  output logic [7:0]            frame_count
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d, shift_q, shift_d;
  logic hold_full_q, hold_full_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic transmit_q, transmit_d, transmit_data_q, transmit_data_d, busy_q, busy_d;
  logic accept, load, last_bit, last_gap;
  always_comb begin
    accept = tx_valid && !hold_full_q;
    load = (state_q == IDLE) && hold_full_q;
    last_bit = bit_q == BW'(DATA_WIDTH - 1);
    last_gap = gap_q == GW'(GAP_CYCLES - 1);
    state_d = state_q == IDLE  ? (hold_full_q ? START : IDLE) :
              state_q == START ? SHIFT :
              state_q == SHIFT ? (last_bit ? GAP : SHIFT) :
                                 (last_gap ? IDLE : GAP);
    hold_full_d = accept || (hold_full_q && !load);
    hold_data_d = accept ? tx_data : hold_data_q;
    shift_d = load ? hold_data_q : state_q == SHIFT ? shift_q << 1 : shift_q;
    bit_d = load ? '0 : state_q == SHIFT ? bit_q + BW'(1) : bit_q;
    gap_d = (state_q == GAP && !last_gap) ? gap_q + GW'(1) : '0;
    frame_count_d = frame_count_q + 8'(state_q == SHIFT && last_bit);
    transmit_d = state_d == START;
    transmit_data_d = (state_d == SHIFT) && shift_d[DATA_WIDTH-1];
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      frame_count_q <= '0;
      transmit_q <= 1'b0;
      transmit_data_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      frame_count_q <= frame_count_d;
      transmit_q <= transmit_d;
      transmit_data_q <= transmit_data_d;
      busy_q <= busy_d;
    end
  end
  assign tx_ready = !hold_full_q;
  assign transmit = transmit_q;
  assign transmit_data = transmit_data_q;
  assign busy = busy_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: scoreboard and vector-table bench for tx_serializer
module tb_tx_serializer;
  logic clk, clr, tx_valid, tx_ready, transmit, transmit_data, busy;
  logic [7:0] tx_data, frame_count;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, pulses = 0, last_start = 0, prev_start = 0, nb = 0;
  logic cap = 1'b0;
  logic [7:0] word, exp_word;
  logic [7:0] q[$];
  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;
    int gap;
  } vec_t;
  vec_t vecs[5];
  tx_serializer #(.DATA_WIDTH(8), .GAP_CYCLES(2)) dut (
    .clk(clk),
    .clr(clr),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .transmit(transmit),
    .transmit_data(transmit_data),
    .busy(busy),
    .frame_count(frame_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      cap = 1'b0;
      q.delete();
    end else if (transmit) begin
      chk("start_bit_zero", {31'd0, transmit_data}, 32'd0);
      pulses++;
      prev_start = last_start;
      last_start = cyc;
      cap = 1'b1;
      nb = 0;
      word = '0;
    end else if (cap) begin
      word = {word[6:0], transmit_data};
      nb++;
      if (nb == 8) begin
        cap = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_frame", {24'd0, word}, 32'hFFFF_FFFF);
        end else begin
          exp_word = q.pop_front();
          chk("frame_bits", {24'd0, word}, {24'd0, exp_word});
        end
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic [7:0] bits, output int waited);
    waited = 0;
    tx_valid = 1'b1;
    tx_data = d;
    while (!tx_ready && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 300) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    q.push_back(bits);
    #1;
    tx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!(busy == 1'b0 && tx_ready && q.size() == 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", {31'd0, n >= 300}, 32'd0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    chk({tag, "_transmit"}, {31'd0, transmit}, 32'd0);
    chk({tag, "_transmit_data"}, {31'd0, transmit_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame_count"}, {24'd0, frame_count}, 32'd0);
  endtask
  initial begin
    int w, n, hits, p0;
    logic [7:0] a5;
    vecs[0] = '{8'h01, 8'b0000_0001, 0};
    vecs[1] = '{8'h80, 8'b1000_0000, 3};
    vecs[2] = '{8'hC3, 8'b1100_0011, 0};
    vecs[3] = '{8'h5A, 8'b0101_1010, 1};
    vecs[4] = '{8'hFF, 8'b1111_1111, 0};
    clr = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h99;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("reset");
    end
    clr = 1'b0;
    tx_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_reset_outputs("post_reset");
    send(8'h0F, 8'b0000_1111, w);
    n = 0;
    while (!transmit && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_start_seen", {31'd0, transmit}, 32'd1);
    send(8'h55, 8'b0101_0101, w);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("abort_bit4", {31'd0, transmit_data}, 32'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_reset_outputs("abort");
    hits = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      hits += int'(transmit);
    end
    chk("abort_no_resend", hits, 32'd0);
    chk("abort_frame_count", {24'd0, frame_count}, 32'd0);
    a5 = 8'hA5;
    send(a5, 8'b1010_0101, w);
    for (int i = 0; i < 13; i++) begin
      chk("a5_transmit", {31'd0, transmit}, {31'd0, i == 1});
      chk("a5_data", {31'd0, transmit_data}, (i >= 2 && i <= 9) ? {31'd0, a5[9-i]} : 32'd0);
      chk("a5_busy", {31'd0, busy}, {31'd0, i >= 1 && i <= 11});
      @(posedge clk);
      #1;
    end
    chk("a5_frame_count", {24'd0, frame_count}, 32'd1);
    send(8'h3C, 8'b0011_1100, w);
    send(8'hFF, 8'b1111_1111, w);
    chk("b2b_ready_wait", w, 32'd1);
    wait_idle();
    chk("b2b_start_spacing", last_start - prev_start, 32'd12);
    chk("b2b_frame_count", {24'd0, frame_count}, 32'd3);
    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].bits, w);
      repeat (vecs[k].gap) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("vec_frame_count", {24'd0, frame_count}, 32'd8);
    send(8'h33, 8'b0011_0011, w);
    tx_valid = 1'b1;
    tx_data = 8'h11;
    @(posedge clk);
    #1;
    tx_data = 8'h22;
    send(8'h22, 8'b0010_0010, w);
    wait_idle();
    chk("bp_frame_count", {24'd0, frame_count}, 32'd10);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 255; i++) send(8'h00, 8'h00, w);
    wait_idle();
    chk("wrap_pre_count", {24'd0, frame_count}, 32'd255);
    send(8'h00, 8'h00, w);
    wait_idle();
    chk("wrap_count", {24'd0, frame_count}, 32'd0);
    chk("wrap_pulses", pulses - p0, 32'd256);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
